// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// The latched-request struct is sized by DMEM_NBITS. Instances that override
// NBITS must keep it equal to this constant.
package dmem_pkg;

  // Default data word width; the word address is [DMEM_NBITS-1:2]
  localparam int DMEM_NBITS = 8;

  // Default number of extra busy cycles before an access commits (0..15)
  localparam int DMEM_WAIT_CYCLES = 2;

  // Wait-state counter width, wide enough for the largest legal WAIT_CYCLES
  localparam int CNT_BITS = 4;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_t;

  // Request captured at accept. Only these values are used while BUSY.
  typedef struct packed {
    logic [DMEM_NBITS-1:2] addr;
    logic [DMEM_NBITS-1:0] wdata;
    logic                  is_write;
  } dmem_req_t;

  // Counter preload on accept. BUSY runs while the count walks from this
  // value down to zero, which gives exactly wait_cycles busy cycles.
  function automatic logic [CNT_BITS-1:0] wait_load(input int wait_cycles);
    if (wait_cycles == 0) begin
      return '0;
    end
    return CNT_BITS'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array for the data memory.
// Write and read both happen on the clock edge. rdata is registered and only
// changes on a read strobe, so the load result stays put between loads.
// Reset synchronously clears every word and the read register.
module dmem_array #(
  parameter int NBITS = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem_reg [DEPTH];
  logic [NBITS-1:0] rdata_reg;
  logic [DEPTH-1:0] word_we;

  // One write-enable per word, decoded from the shared address
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = we && (addr == AW'(gi));
    end
  endgenerate

  // Word storage: reset clears all words and takes priority over a pending write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) begin
          mem_reg[i] <= wdata;
        end
      end
    end
  end

  // Registered read port that holds its value until the next read strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder for the load/store port of the single-cycle datapath.
// An access request (MemRead/MemWrite level) is accepted in IDLE. It waits
// WAIT_CYCLES busy cycles, commits on the last one, and then pulses Done for
// one cycle. Stall freezes the PC from the request cycle up to the commit.
// Requests are serialised, so a read that follows a write to the same
// address always sees the new data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NBITS       = DMEM_NBITS,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES,
  parameter int DEPTH       = 2 ** (NBITS - 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:2] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] ReadData,
  output logic             Stall,
  output logic             Done,
  output logic             Conflict
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  dmem_state_t         state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  dmem_req_t           req_reg, req_next;
  logic                conflict_reg, conflict_next;
  logic                done_reg;

  logic                req_any;
  logic                mem_we;
  logic                mem_re;
  logic [NBITS-1:2]    mem_addr;
  logic [NBITS-1:0]    mem_wdata;

  assign req_any = MemRead | MemWrite;

  // State register, wait counter, request latch, sticky conflict flag and Done flop
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_reg      <= '0;
      conflict_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_reg      <= req_next;
      conflict_reg <= conflict_next;
      // Done comes from a flop; it is high exactly while the FSM sits in DONE
      done_reg     <= (state_next == DONE);
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, single-cycle DONE
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_next      = req_reg;
    conflict_next = conflict_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          // Write wins when both requests are raised together
          req_next.addr     = Address;
          req_next.wdata    = WriteData;
          req_next.is_write = MemWrite;
          if (MemRead && MemWrite) begin
            conflict_next = 1'b1;
          end
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // Live request inputs are ignored here; only the latched request matters
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_BITS'(1);
        end
      end
      DONE: begin
        // Requests are not sampled in DONE; a held request is taken in the next IDLE
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output and array-control decode: Stall plus the commit strobes
  always_comb begin
    Stall     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = req_reg.addr;
    mem_wdata = req_reg.wdata;
    case (state_reg)
      IDLE: begin
        Stall = req_any;
        // With no wait states the access commits on the accepting edge itself,
        // so the array is fed from the live inputs instead of the latch
        if (req_any && (WAIT_CYCLES == 0)) begin
          mem_addr  = Address;
          mem_wdata = WriteData;
          mem_we    = MemWrite;
          mem_re    = MemRead & ~MemWrite;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_reg == '0) begin
          mem_we = req_reg.is_write;
          mem_re = ~req_reg.is_write;
        end
      end
      default: begin
        Stall = 1'b0;
      end
    endcase
  end

  dmem_array #(
    .NBITS (NBITS),
    .DEPTH (DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (ReadData)
  );

  assign Done     = done_reg;
  assign Conflict = conflict_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Three instances share one clock and use
// WAIT_CYCLES of 2, 0 and 3. Each has its own reset and request inputs.
// Every access pushes its expected outcome onto a scoreboard queue. A monitor
// pops the queue on each Done pulse and checks ReadData against a reference
// memory model.
module tb_dmem_responder;

  localparam int NB    = 8;
  localparam int ND    = 3;
  localparam int WORDS = 64;

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  logic          clock = 1'b0;
  logic          reset      [ND];
  logic [NB-1:2] address    [ND];
  logic [NB-1:0] write_data [ND];
  logic          mem_read   [ND];
  logic          mem_write  [ND];
  logic [NB-1:0] read_data  [ND];
  logic          stall      [ND];
  logic          done       [ND];
  logic          conflict   [ND];

  typedef struct packed {
    logic [1:0]    dut;
    logic          is_read;
    logic [NB-1:0] data;
  } sb_item_t;

  sb_item_t      sb_q [$];
  logic [NB-1:0] model_mem [ND][WORDS];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      dmem_responder #(
        .NBITS       (NB),
        .WAIT_CYCLES (wait_of(gi))
      ) u_dut (
        .clock     (clock),
        .reset     (reset[gi]),
        .Address   (address[gi]),
        .WriteData (write_data[gi]),
        .MemRead   (mem_read[gi]),
        .MemWrite  (mem_write[gi]),
        .ReadData  (read_data[gi]),
        .Stall     (stall[gi]),
        .Done      (done[gi]),
        .Conflict  (conflict[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model(input int k);
    for (int a = 0; a < WORDS; a++) begin
      model_mem[k][a] = '0;
    end
  endtask

  // Hold reset for two edges; returns #1 after a rising edge
  task automatic apply_reset(input int k);
    reset[k]     = 1'b1;
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset[k] = 1'b0;
    clear_model(k);
  endtask

  // One access started #1 after a rising edge (cycle 0). Checks Stall and Done
  // for cycles 0..W+1 and optionally scrambles Address/WriteData while busy.
  task automatic access(input int k, input bit wr, input bit rd,
                        input logic [NB-3:0] addr, input logic [NB-1:0] wd,
                        input bit hold, input bit scramble, input string tag);
    int       w;
    sb_item_t it;
    w             = wait_of(k);
    address[k]    = addr;
    write_data[k] = wd;
    mem_write[k]  = wr;
    mem_read[k]   = rd;
    it.dut        = 2'(k);
    it.is_read    = rd && !wr;
    it.data       = (rd && !wr) ? model_mem[k][addr] : '0;
    if (wr) begin
      model_mem[k][addr] = wd;
    end
    sb_q.push_back(it);
    $display("txn %s dut=%0d wr=%0d rd=%0d addr=0x%02h wdata=0x%02h", tag, k, wr, rd, addr, wd);
    for (int c = 0; c <= w + 1; c++) begin
      @(negedge clock);
      check({tag, "_stall"}, 32'(stall[k]), 32'(c <= w));
      check({tag, "_done"}, 32'(done[k]), 32'(c == w + 1));
      @(posedge clock);
      #1;
      if (scramble && c == 0) begin
        address[k]    = ~addr;
        write_data[k] = ~wd;
      end
    end
    if (!hold) begin
      mem_write[k] = 1'b0;
      mem_read[k]  = 1'b0;
    end
  endtask

  // Start a write, then assert reset during the second busy cycle
  task automatic abort_write(input int k, input logic [NB-3:0] addr,
                             input logic [NB-1:0] wd, input string tag);
    address[k]    = addr;
    write_data[k] = wd;
    mem_write[k]  = 1'b1;
    mem_read[k]   = 1'b0;
    $display("txn %s dut=%0d write aborted by reset addr=0x%02h wdata=0x%02h", tag, k, addr, wd);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check({tag, "_stall_pre"}, 32'(stall[k]), 32'd1);
      @(posedge clock);
      #1;
    end
    reset[k]     = 1'b1;
    mem_write[k] = 1'b0;
    @(negedge clock);
    check({tag, "_stall_busy2"}, 32'(stall[k]), 32'd1);
    check({tag, "_done_busy2"}, 32'(done[k]), 32'd0);
    @(posedge clock);
    #1;
    reset[k] = 1'b0;
    clear_model(k);
    for (int c = 0; c < wait_of(k) + 3; c++) begin
      @(negedge clock);
      check({tag, "_idle_stall"}, 32'(stall[k]), 32'd0);
      check({tag, "_no_done"}, 32'(done[k]), 32'd0);
      @(posedge clock);
      #1;
    end
  endtask

  // Scoreboard monitor: every Done must match a queued access
  always @(negedge clock) begin
    for (int k = 0; k < ND; k++) begin
      if (done[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("done_without_request", 32'(done[k]), 32'd0);
        end else begin
          sb_item_t it;
          it = sb_q.pop_front();
          check("sb_dut", 32'(k), 32'(it.dut));
          if (it.is_read) begin
            check("read_data", 32'(read_data[k]), 32'(it.data));
            $display("done dut=%0d read_data=0x%02h expected=0x%02h", k, read_data[k], it.data);
          end else begin
            $display("done dut=%0d write committed", k);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < ND; k++) begin
      reset[k]      = 1'b1;
      address[k]    = '0;
      write_data[k] = '0;
      mem_read[k]   = 1'b0;
      mem_write[k]  = 1'b0;
      clear_model(k);
    end
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < ND; k++) begin
      reset[k] = 1'b0;
    end

    // Reset state
    @(negedge clock);
    for (int k = 0; k < ND; k++) begin
      check("rst_read_data", 32'(read_data[k]), 32'd0);
      check("rst_done", 32'(done[k]), 32'd0);
      check("rst_stall", 32'(stall[k]), 32'd0);
      check("rst_conflict", 32'(conflict[k]), 32'd0);
    end
    @(posedge clock);
    #1;

    // WAIT_CYCLES=2: basic write/read, read of a cleared word
    access(0, 1'b1, 1'b0, 6'h05, 8'hA5, 1'b0, 1'b0, "w2_wr05");
    access(0, 1'b0, 1'b1, 6'h05, 8'h00, 1'b0, 1'b0, "w2_rd05");
    access(0, 1'b0, 1'b1, 6'h2A, 8'h00, 1'b0, 1'b0, "w2_rd2a_clr");

    // Inputs change during BUSY: the latched values must be used
    access(0, 1'b1, 1'b0, 6'h20, 8'h3C, 1'b0, 1'b1, "w2_wr20_scr");
    access(0, 1'b0, 1'b1, 6'h20, 8'h00, 1'b0, 1'b1, "w2_rd20");
    access(0, 1'b0, 1'b1, 6'h1F, 8'h00, 1'b0, 1'b0, "w2_rd1f");

    // Both requests at once: write wins, Conflict sticks until reset
    check("conflict_before", 32'(conflict[0]), 32'd0);
    access(0, 1'b1, 1'b1, 6'h10, 8'h7E, 1'b0, 1'b0, "w2_conf");
    check("conflict_set", 32'(conflict[0]), 32'd1);
    access(0, 1'b0, 1'b1, 6'h10, 8'h00, 1'b0, 1'b0, "w2_conf_rd10");
    check("conflict_sticky", 32'(conflict[0]), 32'd1);
    apply_reset(0);
    @(negedge clock);
    check("conflict_cleared", 32'(conflict[0]), 32'd0);
    check("rst2_read_data", 32'(read_data[0]), 32'd0);
    @(posedge clock);
    #1;
    access(0, 1'b0, 1'b1, 6'h10, 8'h00, 1'b0, 1'b0, "w2_rd10_after_rst");

    // Reset on the commit cycle of a WAIT_CYCLES=2 write
    abort_write(0, 6'h30, 8'h99, "w2_abort");
    access(0, 1'b0, 1'b1, 6'h30, 8'h00, 1'b0, 1'b0, "w2_rd30_after_abort");

    // WAIT_CYCLES=0: held requests, Done every 2 cycles, top address
    access(1, 1'b1, 1'b0, 6'h00, 8'h11, 1'b1, 1'b0, "w0_wr00");
    access(1, 1'b1, 1'b0, 6'h01, 8'h22, 1'b1, 1'b0, "w0_wr01");
    access(1, 1'b1, 1'b0, 6'h3F, 8'h33, 1'b1, 1'b0, "w0_wr3f");
    access(1, 1'b0, 1'b1, 6'h00, 8'h00, 1'b1, 1'b0, "w0_rd00");
    access(1, 1'b0, 1'b1, 6'h01, 8'h00, 1'b1, 1'b0, "w0_rd01");
    access(1, 1'b0, 1'b1, 6'h3F, 8'h00, 1'b0, 1'b0, "w0_rd3f");

    // WAIT_CYCLES=3: normal access, then a write aborted in the second BUSY cycle
    access(2, 1'b1, 1'b0, 6'h08, 8'h5A, 1'b0, 1'b0, "w3_wr08");
    access(2, 1'b0, 1'b1, 6'h08, 8'h00, 1'b0, 1'b0, "w3_rd08");
    abort_write(2, 6'h08, 8'hFF, "w3_abort");
    access(2, 1'b0, 1'b1, 6'h08, 8'h00, 1'b0, 1'b0, "w3_rd08_after_abort");

    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory with a request/done handshake and configurable wait states. It serves the load/store port of the single-cycle datapath. The datapath drives `Address`/`WriteData`, and the controller drives `MemRead`/`MemWrite`. This block returns `ReadData`, holds `Stall` while an access is in flight, and pulses `Done` when the access completes so the controller can advance the PC.

## Interface
- `NBITS`, 8: data word width; address bus is `[NBITS-1:2]`.
- `WAIT_CYCLES`, 2: extra busy cycles before each access commits; legal range 0..15.
- `DEPTH`, 2**(NBITS-2): number of words (64 at default).

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `Address`, in, `[NBITS-1:2]`: word address from the datapath ALU result.
- `WriteData`, in, NBITS: store data (datapath RS2).
- `MemRead`, in, 1: load request, level, held until `Done`.
- `MemWrite`, in, 1: store request, level, held until `Done`.
- `ReadData`, out, NBITS: load result, registered, holds its value between loads.
- `Stall`, out, 1: freeze PC and register-file write while high.
- `Done`, out, 1: one-cycle pulse marking completion of the accepted access.
- `Conflict`, out, 1: sticky flag, set when `MemRead` and `MemWrite` are both high at accept.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If `MemWrite` or `MemRead` is high, latch `Address`, `WriteData` and the operation (write wins if both are high; also set `Conflict`).
  - If `WAIT_CYCLES == 0`, perform the access on this edge and go to DONE.
  - Otherwise load the counter with `WAIT_CYCLES-1` and go to BUSY.
- **BUSY**
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access on this edge, then go to DONE.
  - Request inputs are ignored in BUSY; only latched values are used.
- **Access**
  - Write: `mem[addr_q] <= wdata_q`.
  - Read: `ReadData <= mem[addr_q]`.
- **DONE**: `Done`=1, `Stall`=0, unconditional return to IDLE. Requests are not sampled in DONE.
- `Stall` = (IDLE & (`MemRead` | `MemWrite`)) | BUSY. It is combinational, so the controller sees it in the request cycle.
- Back-to-back: if a request stays high (the next instruction is also memory), the new access is accepted in the IDLE cycle after DONE.
- Address is always in range, because the width equals log2(DEPTH); no wrap logic is needed.
- Read-after-write to the same address returns the new data, since accesses are serialized.
- On reset:
  - State goes to IDLE and the counter to 0.
  - All `DEPTH` words, `ReadData` and `Conflict` are cleared to 0.
  - `Done`=0; `Stall` follows its IDLE equation.
- Reset during BUSY aborts the access. No memory write is committed, because the reset branch has priority on the same edge.

## Timing
- Request first seen high in IDLE at cycle 0 (the latching edge ends cycle 0):
  - `Done` is high in cycle `WAIT_CYCLES+1`.
  - `Stall` is high in cycles 0..`WAIT_CYCLES`.
- Load data is valid on `ReadData` in the `Done` cycle and stays valid until the next read commits.
- Minimum issue interval for held requests: `WAIT_CYCLES+2` cycles.
- All outputs except `Stall` come directly from flops.

## Structure
- Shared package `dmem_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t`.
  - Default `NBITS` and `WAIT_CYCLES` constants.
  - `typedef struct {addr, wdata, is_write}` for the latched request.
- Sub-module `dmem_array`:
  - Parameters `NBITS`, `DEPTH`.
  - Single-port synchronous array with `we`, `addr`, `wdata`, registered `rdata`, and a synchronous clear on reset.
- The FSM, counter and request latch live in `dmem_responder`.

## Test plan
- `WAIT_CYCLES`=2: write 0xA5 to address 0x05, then read 0x05.
  - Expect `Done` in cycle 3 of each access.
  - `Stall` high for cycles 0–2.
  - `ReadData`=0xA5 in the read's `Done` cycle.
- `WAIT_CYCLES`=0: hold `MemWrite` with data 0x11, 0x22, 0x33 to addresses 0x00, 0x01, 0x3F on successive accepts, then read them back.
  - Expect `Done` every 2 cycles.
  - Read-back yields 0x11, 0x22, 0x33.
  - The 0x3F access confirms the top address.
- After reset, read any address → `ReadData`=0x00.
- Assert `MemRead` and `MemWrite` together with address 0x10 and data 0x7E.
  - Write is performed.
  - `Conflict` goes to 1 and stays 1 until reset.
  - A subsequent read of 0x10 returns 0x7E.
- Start a write of 0xFF to 0x08 with `WAIT_CYCLES`=3, and assert reset in the second BUSY cycle.
  - Expect state IDLE, `Done` never pulses.
  - A following read of 0x08 returns 0x00.
- Change `Address` and `WriteData` during BUSY.
  - The committed access uses the values latched at accept.
